input_debounce: RTL
===================

# input_debounce

Input conditioner that sits directly upstream of the control FSM and drives its `x1` input from a raw, asynchronous, possibly bouncing signal. It synchronizes `din` into `clk`, qualifies every level change with a consecutive-sample debounce counter, and presents a clean registered level `dout`. It also emits single-cycle `rise`/`fall` pulses and a `busy` flag.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal minimum is 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive equal synchronized samples required to accept a change; legal minimum is 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width (derived, not overridden).
- Illegal parameter values stop elaboration with `$error`.

Ports (direction, width, meaning):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `din`  in  1  raw asynchronous input.
- `dout`  out  1  debounced level, registered; connects to the FSM's `x1`.
- `rise`  out  1  one-cycle pulse, coincident with `dout` going 0→1.
- `fall`  out  1  one-cycle pulse, coincident with `dout` going 1→0.
- `busy`  out  1  high while a change is being qualified.
- `glitch_clr`  in  1  synchronous clear of `glitch_cnt`. Present only with `INPUT_DEBOUNCE_GLITCH_CNT_EN`.
- `glitch_cnt`  out  8  count of rejected bounces. Present only with `INPUT_DEBOUNCE_GLITCH_CNT_EN`.

## Operation
- **Synchronizer.** `SYNC_STAGES` flops in series; the last stage is `s`. All stages reset to 0.
- **FSM states:** `LO`, `QUAL_HI`, `HI`, `QUAL_LO`. Reset state is `LO`.
- **LO:**
  - `s=1` → go to `QUAL_HI`, `cnt<=1`.
  - Otherwise stay.
- **QUAL_HI:**
  - `s=0` → go to `LO`, `cnt<=0`, count a glitch.
  - `s=1` and `cnt==DEBOUNCE_CYCLES-1` → go to `HI`, `dout<=1`, `rise<=1`, `cnt<=0`.
  - Otherwise `cnt<=cnt+1`.
- **HI, QUAL_LO:** mirror of `LO` and `QUAL_HI` with `s` inverted. Acceptance sets `dout<=0` and `fall<=1`.
- Any unlisted state encoding → next state `LO`, `dout<=0`.
- `rise`/`fall` are registered. They are high for exactly one cycle and are never high together.
- `busy` is registered and high exactly while the state is `QUAL_HI` or `QUAL_LO`.
- Counter arithmetic is unsigned, `CNT_W` bits. It never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.

## Timing
- **Reset values:** `dout=0`, `rise=0`, `fall=0`, `busy=0`, `glitch_cnt=0`, `cnt=0`, state `LO`.
- **Latency:** `din` stable across edges E1..En updates `dout` and pulses `rise`/`fall` at edge `n = SYNC_STAGES + DEBOUNCE_CYCLES` (default E6).
- **Minimum accepted pulse:** `DEBOUNCE_CYCLES` cycles as seen at `s`. Shorter pulses are rejected and `dout` does not change.
- **Bounce during qualification:** the candidate is aborted at the edge that samples the opposite `s`. No partial credit is kept; a later return restarts from `cnt=1`.
- **`din` high at reset release:** this is treated as a normal change. `dout` rises and `rise` pulses `SYNC_STAGES + DEBOUNCE_CYCLES` edges after release.
- **Reset mid-qualification:** everything returns to reset values immediately and asynchronously. No pulse is emitted.

## Configuration
- Macro: `INPUT_DEBOUNCE_GLITCH_CNT_EN`.
- **Defined:**
  - `glitch_clr` and `glitch_cnt` ports exist.
  - `glitch_cnt` increments by 1 on every aborted qualification (`QUAL_*` → origin state).
  - `glitch_cnt` saturates at 255.
  - `glitch_clr` forces 0 on the next edge and wins over a simultaneous increment.
- **Undefined:** both ports and the counter logic are absent; all other behaviour is identical.

## Test plan
Defaults used throughout: `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.
- **Reset values:** assert `reset` mid-cycle with `din=1` → all outputs read 0 immediately. Release → `dout`=1 and `rise`=1 for one cycle at the 6th edge after release.
- **Clean edges:** `din` 0→1 held for 10 cycles → `dout` rises at E6 with `rise` one cycle and `busy` high for 3 cycles before it. `din` 1→0 → `fall` one cycle at E6, `dout`=0.
- **Bounce rejection:** `din` high 3 cycles, low 1, high 10 → the first burst is rejected and `dout` stays 0. `dout` rises 6 edges after the final rising `din`. With the macro, `glitch_cnt`=1.
- **Short pulse:** single-cycle `din` high pulse → `dout`, `rise` and `fall` never assert. `busy` is high for 1 cycle.
- **Reset mid-qualification:** assert `reset` while `busy`=1 → `busy`=0 and the state is `LO`. No `rise` is produced afterward while `din`=0.
- **Glitch counter (macro on):** 300 rejected bounces → `glitch_cnt` saturates at 255. `glitch_clr` asserted on the same edge as a further abort → `glitch_cnt`=0.

Source files
------------

// File: rtl/input_debounce.sv
// input_debounce: synchronizes a raw asynchronous input and debounces it into a clean level with rise/fall pulses.
// Optional rejected-bounce counter (glitch_clr/glitch_cnt) is enabled by defining INPUT_DEBOUNCE_GLITCH_CNT_EN.
module input_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
   input  logic       glitch_clr,
   output logic [7:0] glitch_cnt,
`endif
   output logic       dout,
   output logic       rise,
   output logic       fall,
   output logic       busy
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("input_debounce: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("input_debounce: DEBOUNCE_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {LO, QUAL_HI, HI, QUAL_LO} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   dout_q, dout_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], din};
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         LO: if (s) begin
            state_d = QUAL_HI;
            cnt_d   = CNT_W'(1);
         end
         QUAL_HI: if (!s) begin
            state_d = LO;
            cnt_d   = '0;
         end else if (cnt_q == CNT_MAX) begin
            state_d = HI;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
         end else cnt_d = cnt_q + CNT_W'(1);
         HI: if (!s) begin
            state_d = QUAL_LO;
            cnt_d   = CNT_W'(1);
         end
         QUAL_LO: if (s) begin
            state_d = HI;
            cnt_d   = '0;
         end else if (cnt_q == CNT_MAX) begin
            state_d = LO;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
         end else cnt_d = cnt_q + CNT_W'(1);
         default: begin
            state_d = LO;
            dout_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == QUAL_HI) || (state_d == QUAL_LO);
   end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_q, glitch_d;
   logic       abort;
   // An abort is any qualification that sees the original level again before acceptance.
   assign abort = (state_q == QUAL_HI && !s) || (state_q == QUAL_LO && s);
   always_comb
      glitch_d = glitch_clr ? 8'd0 : (abort && glitch_q != 8'hff) ? glitch_q + 8'd1 : glitch_q;
   assign glitch_cnt = glitch_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= LO;
         sync_q   <= '0;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
         glitch_q <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         busy_q   <= busy_d;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
         glitch_q <= glitch_d;
`endif
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;
endmodule
